ise_sort_engine: RTL and testbench

Parametrised image sorting engine, the next generation of the fixed 32-image, 128×128 ISE. It streams RGB pixels grouped by image, classifies each image by dominant colour, and ranks images by class and by dominant-channel intensity. It then emits the sorted image indices with a ready/valid handshake. Image count, image size, component width and sort direction are all configurable.

---
 rtl/ise_pkg.sv | 45 ++++
 rtl/ise_sort_table.sv | 72 +++++++
 rtl/ise_sort_engine.sv | 251 +++++++++++++++++++++++++
 tb/tb_ise_sort_engine.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ise_pkg.sv
// ise_pkg: shared types for the image sort engine.
// Colour classes, FSM states and the sort-table entry. The entry fields use
// fixed upper-bound widths so one packed type serves every configuration;
// the engine zero-extends its narrower key and index into them.
package ise_pkg;

   localparam int KEY_MAX_W = 32;
   localparam int IDX_MAX_W = 16;

   typedef enum logic [1:0] {
      RED   = 2'd0,
      GREEN = 2'd1,
      BLUE  = 2'd2
   } color_e;

   typedef enum logic [1:0] {
      ST_ACCUM  = 2'd0,
      ST_INSERT = 2'd1,
      ST_OUTPUT = 2'd2
   } state_e;

   typedef struct packed {
      color_e                 cls;
      logic [KEY_MAX_W-1:0]   key;
      logic [IDX_MAX_W-1:0]   idx;
   } ise_entry_t;

   // True when stored entry e belongs ahead of new entry n.
   // Class ascending, then key (direction by desc), then lower index first;
   // an equal index keeps the stored entry first so duplicates stay stable.
   function automatic logic entry_precedes(input ise_entry_t e,
                                           input ise_entry_t n,
                                           input logic       desc);
      logic r;
      if (e.cls != n.cls) begin
         r = (e.cls < n.cls);
      end else if (e.key != n.key) begin
         r = desc ? (e.key > n.key) : (e.key < n.key);
      end else begin
         r = (e.idx <= n.idx);
      end
      return r;
   endfunction

endpackage

// File: rtl/ise_sort_table.sv
// ise_sort_table: insertion-sorted entry table with a single read port.
// Every slot compares itself against the incoming entry in parallel. Because
// the table is always sorted, the slots that precede the new entry form a
// prefix; the first non-preceding slot takes the new entry, and every slot
// above it takes its lower neighbour.
module ise_sort_table
   import ise_pkg::*;
#(
   parameter int DEPTH = 32,
   parameter int IW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_clr,
   input  logic             i_ins,
   input  logic             i_desc,
   input  ise_entry_t       i_entry,
   input  logic [IW-1:0]    i_rd_addr,
   output color_e           o_rd_cls,
   output logic [IW-1:0]    o_rd_idx
);

   ise_entry_t         r_tab [DEPTH];
   logic [DEPTH-1:0]   r_vld;

   logic [DEPTH-1:0]   w_prec;
   logic [DEPTH:0]     w_prec_ext;
   ise_entry_t         w_tab_nxt [DEPTH];
   logic [DEPTH-1:0]   w_vld_nxt;

   // A virtual slot below slot 0 always precedes, so slot 0 takes the new
   // entry whenever nothing stored precedes it.
   assign w_prec_ext[0] = 1'b1;

   for (genvar g = 0; g < DEPTH; g++) begin : g_slot
      ise_entry_t w_below;
      logic       w_below_vld;

      if (g == 0) begin : g_bottom
         assign w_below     = '0;
         assign w_below_vld = 1'b0;
      end else begin : g_upper
         assign w_below     = r_tab[g-1];
         assign w_below_vld = r_vld[g-1];
      end

      assign w_prec[g]       = r_vld[g] && entry_precedes(r_tab[g], i_entry, i_desc);
      assign w_prec_ext[g+1] = w_prec[g];
      assign w_tab_nxt[g]    = w_prec[g] ? r_tab[g] : (w_prec_ext[g] ? i_entry : w_below);
      assign w_vld_nxt[g]    = w_prec[g] ? r_vld[g] : (w_prec_ext[g] ? 1'b1 : w_below_vld);
   end

   // Table storage: clear at end of frame set, shift-insert on request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) r_tab[i] <= '0;
         r_vld <= '0;
      end else if (i_clr) begin
         for (int i = 0; i < DEPTH; i++) r_tab[i] <= '0;
         r_vld <= '0;
      end else if (i_ins) begin
         for (int i = 0; i < DEPTH; i++) r_tab[i] <= w_tab_nxt[i];
         r_vld <= w_vld_nxt;
      end else begin
         r_vld <= r_vld;
      end
   end

   assign o_rd_cls = r_tab[i_rd_addr].cls;
   assign o_rd_idx = r_tab[i_rd_addr].idx[IW-1:0];

endmodule

// File: rtl/ise_sort_engine.sv
// ise_sort_engine: per-image dominant-colour classifier and sorter.
// Pixels are accumulated per image, each finished image is classified and
// inserted into a sorted table, and after IMG_NUM images the table is
// streamed out in order. Build option ISE_OUT_READY_EN adds the out_ready
// port for consumer backpressure; without it the stream never stalls.
module ise_sort_engine
   import ise_pkg::*;
#(
   parameter int  IMG_NUM     = 32,
   parameter int  PIX_PER_IMG = 16384,
   parameter int  CW          = 8,
   localparam int IDX_W       = $clog2(IMG_NUM),
   localparam int CNT_W       = $clog2(PIX_PER_IMG + 1),
   localparam int SUM_W       = CW + $clog2(PIX_PER_IMG)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              pixel_valid,
   input  logic [IDX_W-1:0]  image_in_index,
   input  logic [3*CW-1:0]   pixel_in,
   input  logic              sort_desc,
   output logic              busy,
   output logic              out_valid,
`ifdef ISE_OUT_READY_EN
   input  logic              out_ready,
`endif
   output logic [1:0]        color_index,
   output logic [IDX_W-1:0]  image_out_index
);

   localparam int                ICW      = IDX_W + 1;
   localparam logic [CNT_W-1:0]  LAST_PIX = CNT_W'(PIX_PER_IMG - 1);
   localparam logic [ICW-1:0]    LAST_IMG = ICW'(IMG_NUM - 1);
   localparam logic [IDX_W-1:0]  LAST_ENT = IDX_W'(IMG_NUM - 1);

   state_e             r_state;
   state_e             w_next_state;
   logic               w_accept;
   logic               w_insert;
   logic               w_ready;
   logic               w_last_hs;

   logic [CNT_W-1:0]   r_pix_cnt;
   logic [CNT_W-1:0]   r_cnt_r, r_cnt_g, r_cnt_b;
   logic [SUM_W-1:0]   r_sum_r, r_sum_g, r_sum_b;
   logic [IDX_W-1:0]   r_img_idx;
   logic [ICW-1:0]     r_img_cnt;

   logic [CW-1:0]      w_pr, w_pg, w_pb;
   color_e             w_cls;
   logic [SUM_W-1:0]   w_key;
   ise_entry_t         w_entry;

   logic               r_busy;
   logic               r_out_valid;
   logic [1:0]         r_color;
   logic [IDX_W-1:0]   r_out_idx;
   logic [IDX_W-1:0]   r_rd_ptr;
   logic [IDX_W-1:0]   w_rd_addr;
   color_e             w_rd_cls;
   logic [IDX_W-1:0]   w_rd_idx;

`ifdef ISE_OUT_READY_EN
   assign w_ready = out_ready;
`else
   assign w_ready = 1'b1;
`endif

   assign w_pr = pixel_in[3*CW-1:2*CW];
   assign w_pg = pixel_in[2*CW-1:CW];
   assign w_pb = pixel_in[CW-1:0];

   assign w_last_hs = (r_state == ST_OUTPUT) && r_out_valid && w_ready && (r_rd_ptr == LAST_ENT);

   // FSM state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_ACCUM;
      end else begin
         r_state <= w_next_state;
      end
   end

   // FSM next-state decode.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_ACCUM: begin
            if (w_accept && (r_pix_cnt == LAST_PIX)) w_next_state = ST_INSERT;
            else                                     w_next_state = ST_ACCUM;
         end
         ST_INSERT: begin
            if (r_img_cnt == LAST_IMG) w_next_state = ST_OUTPUT;
            else                       w_next_state = ST_ACCUM;
         end
         ST_OUTPUT: begin
            if (w_last_hs) w_next_state = ST_ACCUM;
            else           w_next_state = ST_OUTPUT;
         end
         default: w_next_state = ST_ACCUM;
      endcase
   end

   // FSM control outputs: pixel acceptance and table insertion strobes.
   always_comb begin
      w_accept = 1'b0;
      w_insert = 1'b0;
      case (r_state)
         ST_ACCUM:  w_accept = pixel_valid;
         ST_INSERT: w_insert = 1'b1;
         ST_OUTPUT: w_accept = 1'b0;
         default:   w_accept = 1'b0;
      endcase
   end

   // Busy flag, registered from the state being entered.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_busy <= 1'b0;
      end else begin
         r_busy <= (w_next_state != ST_ACCUM);
      end
   end

   // Per-image accumulators: dominance counts, channel sums, latched index.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pix_cnt <= '0;
         r_cnt_r   <= '0;
         r_cnt_g   <= '0;
         r_cnt_b   <= '0;
         r_sum_r   <= '0;
         r_sum_g   <= '0;
         r_sum_b   <= '0;
         r_img_idx <= '0;
      end else if (w_insert) begin
         r_pix_cnt <= '0;
         r_cnt_r   <= '0;
         r_cnt_g   <= '0;
         r_cnt_b   <= '0;
         r_sum_r   <= '0;
         r_sum_g   <= '0;
         r_sum_b   <= '0;
      end else if (w_accept) begin
         r_pix_cnt <= r_pix_cnt + CNT_W'(1);
         if (r_pix_cnt == '0) r_img_idx <= image_in_index;
         else                 r_img_idx <= r_img_idx;
         // Strict maximum only; any tie for the maximum counts nowhere.
         if ((w_pr > w_pg) && (w_pr > w_pb))      r_cnt_r <= r_cnt_r + CNT_W'(1);
         else if ((w_pg > w_pr) && (w_pg > w_pb)) r_cnt_g <= r_cnt_g + CNT_W'(1);
         else if ((w_pb > w_pr) && (w_pb > w_pg)) r_cnt_b <= r_cnt_b + CNT_W'(1);
         else                                     r_cnt_r <= r_cnt_r;
         r_sum_r <= r_sum_r + SUM_W'(w_pr);
         r_sum_g <= r_sum_g + SUM_W'(w_pg);
         r_sum_b <= r_sum_b + SUM_W'(w_pb);
      end else begin
         r_pix_cnt <= r_pix_cnt;
      end
   end

   // Image counter across the frame set.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_img_cnt <= '0;
      end else if (w_last_hs) begin
         r_img_cnt <= '0;
      end else if (w_insert) begin
         r_img_cnt <= r_img_cnt + ICW'(1);
      end else begin
         r_img_cnt <= r_img_cnt;
      end
   end

   // Classification: largest count wins, ties resolve R, then G, then B.
   always_comb begin
      if ((r_cnt_r >= r_cnt_g) && (r_cnt_r >= r_cnt_b)) begin
         w_cls = RED;
         w_key = r_sum_r;
      end else if (r_cnt_g >= r_cnt_b) begin
         w_cls = GREEN;
         w_key = r_sum_g;
      end else begin
         w_cls = BLUE;
         w_key = r_sum_b;
      end
   end

   // Assemble the table entry for the image just completed.
   always_comb begin
      w_entry     = '0;
      w_entry.cls = w_cls;
      w_entry.key = KEY_MAX_W'(w_key);
      w_entry.idx = IDX_MAX_W'(r_img_idx);
   end

   // Prefetch the following entry while the current one is being accepted.
   assign w_rd_addr = r_out_valid ? (r_rd_ptr + IDX_W'(1)) : r_rd_ptr;

   ise_sort_table #(
      .DEPTH (IMG_NUM),
      .IW    (IDX_W)
   ) u_table (
      .clk       (clk),
      .rst_n     (reset),
      .i_clr     (w_last_hs),
      .i_ins     (w_insert),
      .i_desc    (sort_desc),
      .i_entry   (w_entry),
      .i_rd_addr (w_rd_addr),
      .o_rd_cls  (w_rd_cls),
      .o_rd_idx  (w_rd_idx)
   );

   // Output register stage: load on entry to OUTPUT, advance on handshake.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_out_valid <= 1'b0;
         r_color     <= 2'd0;
         r_out_idx   <= '0;
         r_rd_ptr    <= '0;
      end else if (r_state == ST_OUTPUT) begin
         if (!r_out_valid) begin
            r_out_valid <= 1'b1;
            r_color     <= w_rd_cls;
            r_out_idx   <= w_rd_idx;
         end else if (w_ready) begin
            if (r_rd_ptr == LAST_ENT) begin
               r_out_valid <= 1'b0;
               r_color     <= 2'd0;
               r_out_idx   <= '0;
               r_rd_ptr    <= '0;
            end else begin
               r_rd_ptr    <= r_rd_ptr + IDX_W'(1);
               r_color     <= w_rd_cls;
               r_out_idx   <= w_rd_idx;
            end
         end else begin
            r_out_valid <= r_out_valid;
         end
      end else begin
         r_out_valid <= 1'b0;
         r_rd_ptr    <= '0;
      end
   end

   assign busy            = r_busy;
   assign out_valid       = r_out_valid;
   assign color_index     = r_color;
   assign image_out_index = r_out_idx;

endmodule

// File: tb/tb_ise_sort_engine.sv
// Directed bench for ise_sort_engine with IMG_NUM=4, PIX_PER_IMG=4, CW=8.
// Expected frames are packed as {e3,e2,e1,e0}, each entry {class[1:0], idx[1:0]}.
module tb_ise_sort_engine;

   logic        clk;
   logic        reset;
   logic        pixel_valid;
   logic [1:0]  image_in_index;
   logic [23:0] pixel_in;
   logic        sort_desc;
   logic        busy;
   logic        out_valid;
   logic        out_ready;
   logic [1:0]  color_index;
   logic [1:0]  image_out_index;

   int n_chk;
   int n_fail;

   ise_sort_engine #(
      .IMG_NUM     (4),
      .PIX_PER_IMG (4),
      .CW          (8)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .pixel_valid     (pixel_valid),
      .image_in_index  (image_in_index),
      .pixel_in        (pixel_in),
      .sort_desc       (sort_desc),
      .busy            (busy),
      .out_valid       (out_valid),
`ifdef ISE_OUT_READY_EN
      .out_ready       (out_ready),
`endif
      .color_index     (color_index),
      .image_out_index (image_out_index)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Four pixels of one image; later pixels carry a wrong index that must be ignored.
   // Afterwards the INSERT cycle is consumed, optionally with junk pixels offered.
   task automatic send_image(input logic [1:0] idx, input logic [23:0] p0, input logic [23:0] p1,
                             input logic [23:0] p2, input logic [23:0] p3, input bit last, input bit junk);
      logic [23:0] px [4];
      px[0] = p0; px[1] = p1; px[2] = p2; px[3] = p3;
      for (int i = 0; i < 4; i++) begin
         pixel_valid    = 1'b1;
         pixel_in       = px[i];
         image_in_index = (i == 0) ? idx : ~idx;
         @(posedge clk); #1;
      end
      pixel_valid    = junk;
      pixel_in       = 24'hFF0000;
      image_in_index = 2'd3;
      n_chk++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL busy_rise idx%0d: busy=%b required 1", idx, busy);
      end
      @(posedge clk); #1;
      pixel_valid = 1'b0;
      if (!last) begin
         n_chk++;
         if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_fall idx%0d: busy=%b required 0", idx, busy);
         end
      end
   endtask

   task automatic send_uniform(input logic [1:0] idx, input logic [23:0] px, input bit last, input bit junk);
      send_image(idx, px, px, px, px, last, junk);
   endtask

   task automatic send_pure(input bit junk);
      send_uniform(2'd0, 24'h00000A, 1'b0, junk);
      send_uniform(2'd1, 24'h0A0000, 1'b0, junk);
      send_uniform(2'd2, 24'h000A00, 1'b0, junk);
      send_uniform(2'd3, 24'h140000, 1'b1, junk);
   endtask

   // Called one cycle after the final INSERT; checks latency, order and hold.
   task automatic collect(input logic [15:0] exp, input string name, input int stall_at);
      logic [3:0] got;
      logic [3:0] want;
      n_chk++;
      if (busy !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL %s lat1: busy=%b out_valid=%b required busy=1 out_valid=0", name, busy, out_valid);
      end
      @(posedge clk); #1;
      n_chk++;
      if (out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL %s lat2: out_valid=%b required 1", name, out_valid);
      end
      for (int k = 0; k < 4; k++) begin
         want = exp[4*k +: 4];
         got  = {color_index, image_out_index};
         n_chk++;
         if (out_valid !== 1'b1 || got !== want) begin
            n_fail++;
            $display("FAIL %s entry%0d: valid=%b cls=%0d idx=%0d required cls=%0d idx=%0d",
                     name, k, out_valid, got[3:2], got[1:0], want[3:2], want[1:0]);
         end
         if (k == stall_at) begin
            out_ready = 1'b0;
            for (int s = 0; s < 3; s++) begin
               @(posedge clk); #1;
               got = {color_index, image_out_index};
               n_chk++;
               if (out_valid !== 1'b1 || got !== want) begin
                  n_fail++;
                  $display("FAIL %s hold%0d: valid=%b cls=%0d idx=%0d required cls=%0d idx=%0d",
                           name, s, out_valid, got[3:2], got[1:0], want[3:2], want[1:0]);
               end
            end
            out_ready = 1'b1;
         end
         @(posedge clk); #1;
      end
      n_chk++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL %s end: out_valid=%b busy=%b required 0 0", name, out_valid, busy);
      end
   endtask

   task automatic check_reset_outputs(input string name);
      n_chk++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || color_index !== 2'd0 || image_out_index !== 2'd0) begin
         n_fail++;
         $display("FAIL %s: busy=%b out_valid=%b color=%0d idx=%0d required all 0",
                  name, busy, out_valid, color_index, image_out_index);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("reset_values");
      reset = 1'b1;
      @(posedge clk); #1;
      check_reset_outputs("after_release");
   endtask

   task automatic test_pure_asc();
      sort_desc = 1'b0;
      send_pure(1'b0);
      collect(16'h8631, "pure_asc", -1);
   endtask

   task automatic test_pure_desc();
      sort_desc = 1'b1;
      send_pure(1'b0);
      collect(16'h8613, "pure_desc", -1);
      sort_desc = 1'b0;
   endtask

   task automatic test_class_tie();
      sort_desc = 1'b0;
      send_image(2'd0, 24'h090000, 24'h000900, 24'h090000, 24'h000900, 1'b0, 1'b0);
      send_uniform(2'd1, 24'h050505, 1'b0, 1'b0);
      send_uniform(2'd2, 24'h000001, 1'b0, 1'b0);
      send_image(2'd3, 24'h000606, 24'h000606, 24'h000606, 24'h000200, 1'b1, 1'b0);
      collect(16'hA710, "class_tie", -1);
   endtask

   task automatic test_equal_keys();
      for (int d = 0; d < 2; d++) begin
         sort_desc = (d == 1);
         send_uniform(2'd2, 24'h070000, 1'b0, 1'b0);
         send_uniform(2'd1, 24'h070000, 1'b0, 1'b0);
         send_uniform(2'd0, 24'h000009, 1'b0, 1'b0);
         send_uniform(2'd3, 24'h000005, 1'b1, 1'b0);
         collect((d == 1) ? 16'hB821 : 16'h8B21, (d == 1) ? "equal_keys_desc" : "equal_keys_asc", -1);
      end
      sort_desc = 1'b0;
   endtask

   task automatic test_busy_ignore();
      sort_desc = 1'b0;
      send_pure(1'b1);
      collect(16'h8631, "busy_ignore", -1);
      send_pure(1'b0);
      collect(16'h8631, "after_busy_ignore", -1);
   endtask

   task automatic test_backpressure();
      sort_desc = 1'b0;
      send_pure(1'b0);
      collect(16'h8631, "backpressure", 1);
   endtask

   task automatic test_reset_mid();
      sort_desc = 1'b0;
      send_uniform(2'd0, 24'h000A00, 1'b0, 1'b0);
      send_uniform(2'd1, 24'h00000A, 1'b0, 1'b0);
      pixel_valid = 1'b1; pixel_in = 24'h0000FF; image_in_index = 2'd2;
      repeat (2) @(posedge clk);
      #1;
      pixel_valid = 1'b0;
      #2 reset = 1'b0;
      #1 check_reset_outputs("reset_mid_frame");
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      send_pure(1'b0);
      collect(16'h8631, "after_mid_reset", -1);
      // Reset while an entry is being presented.
      send_pure(1'b0);
      @(posedge clk); #1;
      n_chk++;
      if (out_valid !== 1'b1 || image_out_index !== 2'd1) begin
         n_fail++;
         $display("FAIL pre_reset_output: out_valid=%b idx=%0d required 1 1", out_valid, image_out_index);
      end
      #2 reset = 1'b0;
      #1 check_reset_outputs("reset_during_output");
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      sort_desc = 1'b1;
      send_pure(1'b0);
      collect(16'h8613, "after_output_reset", -1);
      sort_desc = 1'b0;
   endtask

   initial begin
      n_chk          = 0;
      n_fail         = 0;
      reset          = 1'b0;
      pixel_valid    = 1'b0;
      pixel_in       = 24'h000000;
      image_in_index = 2'd0;
      sort_desc      = 1'b0;
      out_ready      = 1'b1;
      test_reset();
      test_pure_asc();
      test_pure_desc();
      test_class_tie();
      test_equal_keys();
      test_busy_ignore();
`ifdef ISE_OUT_READY_EN
      test_backpressure();
`endif
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
